// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores on a req/ack data bus, formats load
// data, and drives the registered write-back interface and the stall request.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [31:0] inst_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  input  logic        ram_r_ena_i,
  input  logic [31:0] ram_r_addr_i,
  input  logic        ram_w_ena_i,
  input  logic [31:0] ram_w_addr_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        stall_o,
  output logic        wb_reg_w_ena_o,
  output logic [4:0]  wb_reg_w_addr_o,
  output logic [31:0] wb_reg_w_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {StIdle, StBusy} state_e;

  // Counter value in the last BUSY cycle before the access is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_ena_q, wb_ena_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        is_store, is_load, is_mem;
  logic [31:0] acc_addr;
  logic [1:0]  dec_size;
  logic        dec_sign, dec_legal, dec_aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        stall;

  // Only funct3 selects the access; the rest of the instruction is not needed here.
  logic unused_inst;
  assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

  // Access decode: store wins over load; width, signedness and alignment from funct3.
  always_comb begin
    is_store    = ram_w_ena_i;
    is_load     = !ram_w_ena_i && ram_r_ena_i;
    is_mem      = is_store || is_load;
    acc_addr    = is_store ? ram_w_addr_i : ram_r_addr_i;
    dec_size    = 2'd0;
    dec_sign    = 1'b0;
    dec_legal   = 1'b0;
    case (inst_i[14:12])
      3'b000: begin dec_size = 2'd0; dec_sign = 1'b1; dec_legal = 1'b1;    end
      3'b001: begin dec_size = 2'd1; dec_sign = 1'b1; dec_legal = 1'b1;    end
      3'b010: begin dec_size = 2'd2; dec_sign = 1'b0; dec_legal = 1'b1;    end
      3'b100: begin dec_size = 2'd0; dec_sign = 1'b0; dec_legal = is_load; end
      3'b101: begin dec_size = 2'd1; dec_sign = 1'b0; dec_legal = is_load; end
      default: ;
    endcase
    case (dec_size)
      2'd1:    dec_aligned = !acc_addr[0];
      2'd2:    dec_aligned = (acc_addr[1:0] == 2'b00);
      default: dec_aligned = 1'b1;
    endcase
  end

  // Store lane placement: replicate data across lanes, enable only the addressed bytes.
  always_comb begin
    case (dec_size)
      2'd0: begin
        st_be    = 4'b0001 << acc_addr[1:0];
        st_wdata = {4{reg_w_data_i[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << acc_addr[1:0];
        st_wdata = {2{reg_w_data_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = reg_w_data_i;
      end
    endcase
  end

  // Load formatting: pick the lane by latched offset, then sign/zero extend.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dbus_rdata_i[7:0];
      2'd1:    byte_sel = dbus_rdata_i[15:8];
      2'd2:    byte_sel = dbus_rdata_i[23:16];
      default: byte_sel = dbus_rdata_i[31:24];
    endcase
    half_sel = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (size_q)
      2'd0:    load_data = sign_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      2'd1:    load_data = sign_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: load_data = dbus_rdata_i;
    endcase
  end

  // FSM next state, bus/write-back next values and the stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    off_d      = off_q;
    size_d     = size_q;
    sign_d     = sign_q;
    rd_d       = rd_q;
    wb_ena_d   = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!is_mem) begin
          wb_ena_d  = reg_w_ena_i;
          wb_addr_d = reg_w_addr_i;
          wb_data_d = reg_w_data_i;
        end else if (!(dec_legal && dec_aligned)) begin
          misalign_d = 1'b1;
        end else begin
          stall   = 1'b1;
          state_d = StBusy;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {acc_addr[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          off_d   = acc_addr[1:0];
          size_d  = dec_size;
          sign_d  = dec_sign;
          rd_d    = reg_w_addr_i;
        end
      end
      StBusy: begin
        if (dbus_ack_i) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_ena_d  = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = load_data;
          end
        end else if (cnt_q == TimeoutLast) begin
          // Release the pipeline now; the error pulse follows next cycle.
          state_d   = StIdle;
          cnt_d     = 8'd0;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stall drops with reset even while the held inputs still show a memory op.
  assign stall_o = stall && !arst;

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Datapath, bus and write-back registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      sign_q     <= 1'b0;
      rd_q       <= 5'd0;
      wb_ena_q   <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      rd_q       <= rd_d;
      wb_ena_q   <= wb_ena_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dbus_req_o      = req_q;
  assign dbus_we_o       = we_q;
  assign dbus_addr_o     = addr_q;
  assign dbus_wdata_o    = wdata_q;
  assign dbus_be_o       = be_q;
  assign wb_reg_w_ena_o  = wb_ena_q;
  assign wb_reg_w_addr_o = wb_addr_q;
  assign wb_reg_w_data_o = wb_data_q;
  assign misalign_o      = misalign_q;
  assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations checked with immediate assertions.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] inst;
  logic        reg_w_ena;
  logic [4:0]  reg_w_addr;
  logic [31:0] reg_w_data;
  logic        ram_r_ena;
  logic [31:0] ram_r_addr;
  logic        ram_w_ena;
  logic [31:0] ram_w_addr;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        stall;
  logic        wb_ena;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .arst            (arst),
    .inst_i          (inst),
    .reg_w_ena_i     (reg_w_ena),
    .reg_w_addr_i    (reg_w_addr),
    .reg_w_data_i    (reg_w_data),
    .ram_r_ena_i     (ram_r_ena),
    .ram_r_addr_i    (ram_r_addr),
    .ram_w_ena_i     (ram_w_ena),
    .ram_w_addr_i    (ram_w_addr),
    .dbus_req_o      (dbus_req),
    .dbus_we_o       (dbus_we),
    .dbus_addr_o     (dbus_addr),
    .dbus_wdata_o    (dbus_wdata),
    .dbus_be_o       (dbus_be),
    .dbus_rdata_i    (dbus_rdata),
    .dbus_ack_i      (dbus_ack),
    .stall_o         (stall),
    .wb_reg_w_ena_o  (wb_ena),
    .wb_reg_w_addr_o (wb_addr),
    .wb_reg_w_data_o (wb_data),
    .misalign_o      (misalign),
    .bus_err_o       (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    inst       = 32'h0000_0013;
    reg_w_ena  = 1'b0;
    reg_w_addr = 5'd0;
    reg_w_data = 32'd0;
    ram_r_ena  = 1'b0;
    ram_r_addr = 32'd0;
    ram_w_ena  = 1'b0;
    ram_w_addr = 32'd0;
  endtask

  task automatic drive(input logic [31:0] i, input logic we_reg, input logic [4:0] rd,
                       input logic [31:0] d, input logic re, input logic [31:0] ra,
                       input logic wr, input logic [31:0] wa);
    inst = i; reg_w_ena = we_reg; reg_w_addr = rd; reg_w_data = d;
    ram_r_ena = re; ram_r_addr = ra; ram_w_ena = wr; ram_w_addr = wa;
  endtask

  initial begin
    arst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'd0;
    set_idle();
    tick();
    tick();
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_wb_ena", {31'd0, wb_ena}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    arst = 1'b0;
    tick();

    // ADD x5 = 0x1234
    drive(32'h0000_0033, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 32'd0);
    #1 chk("add_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("add_wb_ena", {31'd0, wb_ena}, 32'd1);
    chk("add_wb_addr", {27'd0, wb_addr}, 32'd5);
    chk("add_wb_data", wb_data, 32'h0000_1234);
    set_idle();
    tick();
    chk("idle_wb_ena", {31'd0, wb_ena}, 32'd0);

    // LB x7, 0x103: two BUSY cycles without ack, ack on the third
    drive(32'h0000_0003, 1'b1, 5'd7, 32'd0, 1'b1, 32'h0000_0103, 1'b0, 32'd0);
    #1 chk("lb_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("lb_req", {31'd0, dbus_req}, 32'd1);
    chk("lb_addr", dbus_addr, 32'h0000_0100);
    chk("lb_we", {31'd0, dbus_we}, 32'd0);
    chk("lb_bubble", {31'd0, wb_ena}, 32'd0);
    chk("lb_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("lb_stall2", {31'd0, stall}, 32'd1);
    chk("lb_req2", {31'd0, dbus_req}, 32'd1);
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'h80FF_0000;
    #1 chk("lb_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    set_idle();
    dbus_ack = 1'b0;
    chk("lb_req_done", {31'd0, dbus_req}, 32'd0);
    chk("lb_wb_ena", {31'd0, wb_ena}, 32'd1);
    chk("lb_wb_addr", {27'd0, wb_addr}, 32'd7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);

    // LHU x8, 0x202
    drive(32'h0000_5003, 1'b1, 5'd8, 32'd0, 1'b1, 32'h0000_0202, 1'b0, 32'd0);
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hBEEF_1234;
    tick();
    set_idle();
    dbus_ack = 1'b0;
    chk("lhu_wb_ena", {31'd0, wb_ena}, 32'd1);
    chk("lhu_wb_addr", {27'd0, wb_addr}, 32'd8);
    chk("lhu_wb_data", wb_data, 32'h0000_BEEF);

    // LW x9, 0x200
    drive(32'h0000_2003, 1'b1, 5'd9, 32'd0, 1'b1, 32'h0000_0200, 1'b0, 32'd0);
    tick();
    chk("lw_addr", dbus_addr, 32'h0000_0200);
    dbus_ack = 1'b1;
    tick();
    set_idle();
    dbus_ack = 1'b0;
    chk("lw_wb_data", wb_data, 32'hBEEF_1234);

    // SH 0x302, data 0xABCD; load request also raised to check store priority
    drive(32'h0000_1023, 1'b0, 5'd0, 32'h0000_ABCD, 1'b1, 32'h0000_0777, 1'b1, 32'h0000_0302);
    #1 chk("sh_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("sh_req", {31'd0, dbus_req}, 32'd1);
    chk("sh_we", {31'd0, dbus_we}, 32'd1);
    chk("sh_addr", dbus_addr, 32'h0000_0300);
    chk("sh_be", {28'd0, dbus_be}, 32'h0000_000C);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    dbus_ack = 1'b1;
    #1 chk("sh_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    set_idle();
    dbus_ack = 1'b0;
    chk("sh_wb_ena", {31'd0, wb_ena}, 32'd0);
    chk("sh_req_done", {31'd0, dbus_req}, 32'd0);

    // SB 0x501, data 0x12345678
    drive(32'h0000_0023, 1'b0, 5'd0, 32'h1234_5678, 1'b0, 32'd0, 1'b1, 32'h0000_0501);
    tick();
    chk("sb_be", {28'd0, dbus_be}, 32'h0000_0002);
    chk("sb_wdata", dbus_wdata, 32'h7878_7878);
    dbus_ack = 1'b1;
    tick();
    set_idle();
    dbus_ack = 1'b0;
    chk("sb_wb_ena", {31'd0, wb_ena}, 32'd0);

    // Misaligned LW 0x401
    drive(32'h0000_2003, 1'b1, 5'd10, 32'd0, 1'b1, 32'h0000_0401, 1'b0, 32'd0);
    #1 chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    set_idle();
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_req", {31'd0, dbus_req}, 32'd0);
    chk("mis_wb_ena", {31'd0, wb_ena}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // Timeout: aligned LW with ack withheld; 16th BUSY cycle releases the stall
    drive(32'h0000_2003, 1'b1, 5'd11, 32'd0, 1'b1, 32'h0000_0400, 1'b0, 32'd0);
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("to_stall_%0d", i), {31'd0, stall}, 32'd1);
      chk($sformatf("to_req_%0d", i), {31'd0, dbus_req}, 32'd1);
      tick();
    end
    chk("to_last_stall", {31'd0, stall}, 32'd0);
    chk("to_last_req", {31'd0, dbus_req}, 32'd1);
    chk("to_last_err", {31'd0, bus_err}, 32'd0);
    tick();
    set_idle();
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_req", {31'd0, dbus_req}, 32'd0);
    chk("to_wb_ena", {31'd0, wb_ena}, 32'd0);
    tick();
    chk("to_err_end", {31'd0, bus_err}, 32'd0);

    // Ack arriving in the timeout cycle wins
    drive(32'h0000_2003, 1'b1, 5'd12, 32'd0, 1'b1, 32'h0000_0404, 1'b0, 32'd0);
    tick();
    repeat (15) tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hCAFE_F00D;
    tick();
    set_idle();
    dbus_ack = 1'b0;
    chk("tack_err", {31'd0, bus_err}, 32'd0);
    chk("tack_wb_ena", {31'd0, wb_ena}, 32'd1);
    chk("tack_wb_addr", {27'd0, wb_addr}, 32'd12);
    chk("tack_wb_data", wb_data, 32'hCAFE_F00D);

    // Reset asserted mid-access
    drive(32'h0000_2003, 1'b1, 5'd13, 32'd0, 1'b1, 32'h0000_0600, 1'b0, 32'd0);
    tick();
    chk("rb_req", {31'd0, dbus_req}, 32'd1);
    #2 arst = 1'b1;
    #1 chk("rb_req_async", {31'd0, dbus_req}, 32'd0);
    chk("rb_stall_async", {31'd0, stall}, 32'd0);
    set_idle();
    tick();
    arst = 1'b0;
    chk("rb_wb_ena", {31'd0, wb_ena}, 32'd0);
    drive(32'h0000_0033, 1'b1, 5'd6, 32'h0000_0055, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    set_idle();
    chk("post_add_ena", {31'd0, wb_ena}, 32'd1);
    chk("post_add_addr", {27'd0, wb_addr}, 32'd6);
    chk("post_add_data", wb_data, 32'h0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
